tx_scrambler: RTL and testbench
===============================

TX_SCRAMBLER -- requirements
Module: tx_scrambler

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Clk  input  1  rising-edge clock for all state.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 data_in  input  1  serial PPDU bit stream in order SIGNAL(24), SERVICE(16), DATA(LENGTH*8).
REQ-005 data_in_valid  input  1  data_in qualifier; the block advances only on cycles where it is high.
REQ-006 seed_in  input  7  initial scrambler state, with s[k]=seed_in[k-1]; present only without TX_SCRAMBLER_AUTOSEED_EN.
REQ-007 data_out  output  1  registered output bit.
REQ-008 data_out_valid  output  1  registered copy of data_in_valid.
REQ-009 frame_done  output  1  one-cycle pulse with the last DATA bit (or last SERVICE bit when LENGTH=0).

Function
REQ-010 Latency SHALL be exactly 1 cycle: data_out/data_out_valid at cycle n+1 reflect data_in/data_in_valid at cycle n.
REQ-011 When data_in_valid=0: data_out_valid<=0, and state, counter, LFSR and data_out SHALL hold.
REQ-012 States SHALL be SIGNAL_T, SERVICE_T and DATA_T; the state after reset is SIGNAL_T.
REQ-013 SIGNAL_T: data_out<=data_in unscrambled; leave after 24 valid bits (counter 0..23).
REQ-014 SIGNAL_T: bits at counter 5..16 SHALL be captured LSB-first into the 12-bit LENGTH register.
REQ-015 On the SIGNAL_T->SERVICE_T transition the LFSR SHALL load the seed; an all-zero seed SHALL be replaced by 7'h7F.
REQ-016 Scrambling (SERVICE_T and DATA_T): f=s[4]^s[7]; data_out<=data_in^f; s[1]<=f; s[2..7]<=s[1..6].
REQ-017 SERVICE_T SHALL last 16 valid bits, then go to DATA_T, or to SIGNAL_T with frame_done=1 when LENGTH=0.
REQ-018 DATA_T SHALL last exactly LENGTH*8 valid bits, using a 15-bit counter on {LENGTH,3'b0}; the last bit pulses frame_done and returns to SIGNAL_T.
REQ-019 The counter SHALL reset to 0 on every state transition.
REQ-020 A valid bit in the cycle after the DATA_T->SIGNAL_T transition SHALL be treated as SIGNAL bit 0 (back-to-back frames, no gap needed).
REQ-021 Upstream supplies SERVICE as zeros; non-zero SERVICE input SHALL be scrambled identically, not forced.

Reset
REQ-022 When Reset=1 at a clock edge, the block SHALL set: data_out=0, data_out_valid=0, frame_done=0, state=SIGNAL_T, counter=0, LENGTH=0, LFSR=0.
REQ-023 Reset mid-frame SHALL abort the frame without a frame_done pulse; the next valid bit is SIGNAL bit 0.
REQ-024 Reset SHALL take priority over data_in_valid.

Configuration
REQ-025 With TX_SCRAMBLER_AUTOSEED_EN defined, the seed_in port SHALL be removed.
REQ-026 With TX_SCRAMBLER_AUTOSEED_EN defined, the seed SHALL come from an internal 7-bit frame counter: reset 7'h01, +1 at each SERVICE_T entry, wraps 7'h7F->7'h01 and never 0.
REQ-027 Without TX_SCRAMBLER_AUTOSEED_EN, the seed SHALL be sampled from seed_in at the SIGNAL_T->SERVICE_T transition.

Structure
REQ-028 A shared package SHALL hold the state encoding, SIGNAL_BITS=24, SERVICE_BITS=16, LEN_LSB=5, LEN_MSB=16 and the default seed 7'h7F.
REQ-029 The LFSR SHALL be a sub-module, scr_lfsr7, with ports load, seed, advance, fb; the FSM and counters stay in tx_scrambler.

Verification
REQ-030 Reset, seed 7'h7F, SIGNAL with LENGTH=1, 16 zero SERVICE bits -> SIGNAL echoed 1 cycle late; first 5 SERVICE outputs 0,0,0,0,1.
REQ-031 LENGTH=3, seed 7'h5D, random DATA -> exactly 24 DATA bits scrambled; frame_done high on the 24th only; next bit treated as SIGNAL.
REQ-032 Loopback into the receive descrambler, LENGTH=100, random payload -> recovered DATA bits equal the payload.
REQ-033 Every 3rd cycle data_in_valid=0 across a full frame -> output identical to the gap-free run, with data_out_valid gaps delayed 1 cycle.
REQ-034 Reset at DATA bit 10 -> outputs 0 next cycle, no frame_done, a fresh frame is processed correctly.
REQ-035 LENGTH=0 and seed_in=0 -> LFSR uses 7'h7F; frame_done on the 16th SERVICE bit; the next frame starts directly.

Source files
------------

// File: rtl/tx_scrambler_pkg.sv
// tx_scrambler_pkg: state encoding, PPDU field positions and seed helpers
// shared by the scrambler, its LFSR and the bench.
package tx_scrambler_pkg;
   typedef enum logic [1:0] {
      SIGNAL_T  = 2'd0,
      SERVICE_T = 2'd1,
      DATA_T    = 2'd2
   } state_t;
   localparam int SIGNAL_BITS = 24;
   localparam int SERVICE_BITS = 16;
   localparam int LEN_LSB = 5;
   localparam int LEN_MSB = 16;
   localparam logic [6:0] DEFAULT_SEED = 7'h7F;
   function automatic logic [6:0] fix_seed(input logic [6:0] s);
      return (s == 7'd0) ? DEFAULT_SEED : s;
   endfunction
   // Frame id walks 1..127 and never reaches 0, so it is always a legal seed.
   function automatic logic [6:0] next_frame_id(input logic [6:0] id);
      return (id == 7'h7F) ? 7'h01 : id + 7'd1;
   endfunction
endpackage

// File: rtl/tx_scrambler_if.sv
// tx_scrambler_if: serial bit-stream bus into and out of the scrambler;
// seed_in exists only when TX_SCRAMBLER_AUTOSEED_EN is undefined.
interface tx_scrambler_if;
   logic data_in;
   logic data_in_valid;
   logic data_out;
   logic data_out_valid;
   logic frame_done;
`ifdef TX_SCRAMBLER_AUTOSEED_EN
   modport master (output data_in, data_in_valid, input data_out, data_out_valid, frame_done);
   modport slave (input data_in, data_in_valid, output data_out, data_out_valid, frame_done);
`else
   logic [6:0] seed_in;
   modport master (output data_in, data_in_valid, seed_in, input data_out, data_out_valid, frame_done);
   modport slave (input data_in, data_in_valid, seed_in, output data_out, data_out_valid, frame_done);
`endif
endinterface

// File: rtl/tx_scrambler_lfsr.sv
// scr_lfsr7: x^7+x^4+1 scrambler LFSR; state bit s[k] is held in s_q[k-1].
module scr_lfsr7 (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [6:0] seed,
   input  logic       advance,
   output logic       fb
);
   logic [6:0] s_q, s_d;
   assign fb = s_q[3] ^ s_q[6];
   always_comb s_d = load ? seed : advance ? {s_q[5:0], fb} : s_q;
   always_ff @(posedge clk) s_q <= rst ? 7'd0 : s_d;
endmodule

// File: rtl/tx_scrambler.sv
// tx_scrambler: 802.11a-style PPDU bit scrambler, SIGNAL passed through, SERVICE+DATA scrambled.
// Define TX_SCRAMBLER_AUTOSEED_EN to drop seed_in and seed from an internal frame counter.
module tx_scrambler
   import tx_scrambler_pkg::*;
(
   input logic           Clk,
   input logic           Reset,
   tx_scrambler_if.slave bus
);
   localparam int CW = 15;
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d, data_last;
   logic [11:0] len_q, len_d;
   logic data_out_q, data_out_d, data_out_valid_q, data_out_valid_d, frame_done_q, frame_done_d;
   logic vld, last, fb, load, advance;
   logic [6:0] seed;
   assign vld = bus.data_in_valid;
   assign data_last = {len_q, 3'b000} - CW'(1);
   assign last = (state_q == SIGNAL_T) ? (cnt_q == CW'(SIGNAL_BITS - 1)) :
                 (state_q == SERVICE_T) ? (cnt_q == CW'(SERVICE_BITS - 1)) : (cnt_q == data_last);
`ifdef TX_SCRAMBLER_AUTOSEED_EN
   logic [6:0] frame_id_q, frame_id_d;
   always_comb frame_id_d = load ? next_frame_id(frame_id_q) : frame_id_q;
   always_ff @(posedge Clk) frame_id_q <= Reset ? 7'h01 : frame_id_d;
   assign seed = fix_seed(frame_id_q);
`else
   assign seed = fix_seed(bus.seed_in);
`endif
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= SIGNAL_T;
         cnt_q <= '0;
         len_q <= '0;
         data_out_q <= 1'b0;
         data_out_valid_q <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         len_q <= len_d;
         data_out_q <= data_out_d;
         data_out_valid_q <= data_out_valid_d;
         frame_done_q <= frame_done_d;
      end
   end
   always_comb begin
      state_d = state_q;
      if (vld && last)
         state_d = (state_q == SIGNAL_T) ? SERVICE_T :
                   (state_q == SERVICE_T && len_q != 12'd0) ? DATA_T : SIGNAL_T;
   end
   // LENGTH arrives LSB-first in SIGNAL bits LEN_LSB..LEN_MSB.
   always_comb begin
      cnt_d = !vld ? cnt_q : last ? '0 : cnt_q + CW'(1);
      len_d = len_q;
      for (int i = 0; i <= LEN_MSB - LEN_LSB; i++)
         if (vld && state_q == SIGNAL_T && cnt_q == CW'(LEN_LSB + i)) len_d[i] = bus.data_in;
   end
   always_comb begin
      load = vld && last && state_q == SIGNAL_T;
      advance = vld && state_q != SIGNAL_T;
      data_out_d = !vld ? data_out_q : (state_q == SIGNAL_T) ? bus.data_in : bus.data_in ^ fb;
      data_out_valid_d = vld;
      frame_done_d = vld && last && (state_q == DATA_T || (state_q == SERVICE_T && len_q == 12'd0));
   end
   scr_lfsr7 u_lfsr (
      .clk     (Clk),
      .rst     (Reset),
      .load    (load),
      .seed    (seed),
      .advance (advance),
      .fb      (fb)
   );
   assign bus.data_out = data_out_q;
   assign bus.data_out_valid = data_out_valid_q;
   assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_tx_scrambler.sv
// tb_tx_scrambler: random PPDU frames against a recurrence-based scrambler model,
// checked through an expectation queue plus a loopback descrambler in the monitor.
module tb_tx_scrambler;
   typedef struct {
      bit out;
      bit fd;
      bit lb;
      int kind;
      bit pay;
   } exp_t;
   logic Clk = 1'b0;
   logic Reset = 1'b1;
   tx_scrambler_if bus();
   tx_scrambler dut (.Clk(Clk), .Reset(Reset), .bus(bus));
   always #5 Clk = ~Clk;
   exp_t q[$];
   bit rx[$];
   int errors = 0;
   int checks = 0;
   bit exp_hold = 1'b0;
   logic [6:0] auto_id = 7'h01;
   exp_t m;
   bit mf;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   always @(negedge Clk) begin
      if (bus.data_out_valid === 1'b1) begin
         if (q.size() == 0) chk("unexpected_output", 32'd1, 32'd0);
         else begin
            m = q.pop_front();
            chk("data_out", bus.data_out, m.out);
            chk("frame_done", bus.frame_done, m.fd);
            exp_hold = m.out;
            if (m.lb && m.kind == 0) rx.delete();
            if (m.lb && m.kind == 1) rx.push_back(bus.data_out);
            if (m.lb && m.kind == 2) begin
               mf = rx[rx.size() - 4] ^ rx[rx.size() - 7];
               rx.push_back(mf);
               chk("loopback_payload", bus.data_out ^ mf, m.pay);
            end
         end
      end else begin
         chk("idle_frame_done", bus.frame_done, 32'd0);
         chk("hold_data_out", bus.data_out, exp_hold);
      end
   end
   task automatic drive(input bit v, input bit b);
      @(posedge Clk);
      #1;
      bus.data_in_valid = v;
      bus.data_in = b;
   endtask
   task automatic do_reset();
      @(posedge Clk);
      #1;
      Reset = 1'b1;
      bus.data_in_valid = 1'($urandom);
      bus.data_in = 1'($urandom);
      @(posedge Clk);
      #1;
      Reset = 1'b0;
      bus.data_in_valid = 1'b0;
      exp_hold = 1'b0;
      auto_id = 7'h01;
      @(negedge Clk);
      chk("reset_data_out", bus.data_out, 32'd0);
      chk("reset_data_out_valid", bus.data_out_valid, 32'd0);
      chk("reset_frame_done", bus.frame_done, 32'd0);
   endtask
   // Scrambler sequence as the recurrence f[n] = f[n-4] ^ f[n-7], seeded with s[7]..s[1].
   task automatic send_frame(input int len, input logic [6:0] seed, input int gap,
                             input int abort_at, input bit rnd_srv, input bit lb);
      logic [23:0] sig;
      logic [6:0] s;
      logic [11:0] l12;
      bit fh[$];
      exp_t e;
      int nb, cyc;
      bit b, f;
      l12 = 12'(len);
      sig = 24'($urandom);
      for (int i = 0; i < 12; i++) sig[5 + i] = l12[i];
`ifdef TX_SCRAMBLER_AUTOSEED_EN
      s = auto_id;
      auto_id = (auto_id == 7'h7F) ? 7'h01 : auto_id + 7'd1;
`else
      bus.seed_in = seed;
      s = (seed == 7'd0) ? 7'h7F : seed;
`endif
      for (int k = 7; k >= 1; k--) fh.push_back(s[k - 1]);
      nb = (abort_at >= 0) ? 40 + abort_at : 40 + 8 * len;
      cyc = 0;
      for (int i = 0; i < nb; i++) begin
         while ((gap > 0 && cyc % gap == gap - 1) || (gap < 0 && $urandom_range(3) == 0)) begin
            drive(1'b0, 1'($urandom));
            cyc++;
         end
         b = (i < 24) ? sig[i] : (i < 40 && !rnd_srv) ? 1'b0 : 1'($urandom);
         e.pay = b;
         e.kind = (i < 24) ? 0 : (i < 40) ? 1 : 2;
         e.lb = lb;
         if (i < 24) e.out = b;
         else begin
            f = fh[fh.size() - 4] ^ fh[fh.size() - 7];
            fh.push_back(f);
            e.out = b ^ f;
         end
         e.fd = (abort_at < 0) && (i == nb - 1);
         drive(1'b1, b);
         cyc++;
         q.push_back(e);
      end
   endtask
   initial begin
      bus.data_in = 1'b0;
      bus.data_in_valid = 1'b0;
`ifndef TX_SCRAMBLER_AUTOSEED_EN
      bus.seed_in = 7'h00;
`endif
      do_reset();
      send_frame(1, 7'h7F, 0, -1, 1'b0, 1'b0);
      send_frame(3, 7'h5D, 0, -1, 1'b0, 1'b0);
      send_frame(2, 7'($urandom), 0, -1, 1'b0, 1'b0);
      send_frame(100, 7'($urandom), 0, -1, 1'b0, 1'b1);
      send_frame(5, 7'h33, 3, -1, 1'b0, 1'b0);
      send_frame(4, 7'h11, 0, 10, 1'b0, 1'b0);
      do_reset();
      send_frame(2, 7'h22, 0, -1, 1'b0, 1'b1);
      send_frame(0, 7'h00, 0, -1, 1'b0, 1'b0);
      send_frame(1, 7'h45, 0, -1, 1'b0, 1'b0);
      send_frame(2, 7'($urandom), 0, -1, 1'b1, 1'b0);
      for (int n = 0; n < 6; n++)
         send_frame(int'($urandom_range(6)), 7'($urandom), -1, -1, 1'($urandom), 1'b0);
      send_frame(3, 7'($urandom), -1, -1, 1'b0, 1'b1);
      repeat (4) drive(1'b0, 1'($urandom));
      @(negedge Clk);
      chk("queue_drained", q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
